// File: rtl/pc_fetch_stage_pkg.sv
// Shared types and constants for the PC / instruction-fetch stage.
package pc_fetch_stage_pkg;
  localparam logic [31:0] PC_RESET   = 32'h0000_0000;
  localparam logic [31:0] WORD_BYTES = 32'd4;

  typedef enum logic [1:0] {FETCH, WAIT_RSP, DRAIN} fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } buf_entry_t;
endpackage

// File: rtl/pc_fetch_stage_inst_buffer.sv
// Circular instruction buffer between fetch and decode; head fields hold their
// last value while empty so decode sees stable data.
module fetch_inst_buffer
  import pc_fetch_stage_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  buf_entry_t push_data,
  input  logic       pop,
  input  logic       flush,
  output buf_entry_t head,
  output logic       full,
  output logic       empty
);
  buf_entry_t      mem_q [DEPTH];
  buf_entry_t      last_q, last_d;
  logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [AW:0]     count_q, count_d;
  logic            do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? last_q : mem_q[head_q];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    last_d  = head;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) tail_d = tail_q + AW'(1);
      if (do_pop)  head_d = head_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      last_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      last_q  <= last_d;
    end
  end

  // Storage needs no reset: an entry is only read once count covers it.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[tail_q] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && full));
  end
endmodule

// File: rtl/pc_fetch_stage.sv
// PC register and one-outstanding fetch engine feeding a small instruction
// buffer; redirects flush the buffer and drain any in-flight response.
module pc_fetch_stage
  import pc_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = PC_RESET,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] next_pc_in,
  input  logic        redirect,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic [31:0] pc_plus4,
  input  logic        inst_ready
);
  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic         alive_q;
  logic         buf_push, buf_flush, buf_full, buf_empty;
  buf_entry_t   push_entry, head;

  assign imem_req_addr = fetch_pc_q;
  // fetch_pc has already advanced past the outstanding request.
  assign push_entry    = '{pc: fetch_pc_q - WORD_BYTES, inst: imem_rsp_data};
  assign inst_valid    = !buf_empty;
  assign inst_out      = head.inst;
  assign inst_pc       = head.pc;
  assign pc_plus4      = head.pc + WORD_BYTES;

  always_comb begin
    state_d        = state_q;
    fetch_pc_d     = fetch_pc_q;
    buf_push       = 1'b0;
    buf_flush      = 1'b0;
    imem_req_valid = alive_q && (state_q == FETCH) && !buf_full && !redirect;
    if (redirect) begin
      buf_flush  = 1'b1;
      fetch_pc_d = next_pc_in & ~32'h3;
      // A response landing in this same cycle closes the outstanding request,
      // so there is nothing left to drain.
      state_d    = (state_q != FETCH && !imem_rsp_valid) ? DRAIN : FETCH;
    end else begin
      case (state_q)
        FETCH: if (imem_req_valid && imem_req_ready) begin
          state_d    = WAIT_RSP;
          fetch_pc_d = fetch_pc_q + WORD_BYTES;
        end
        WAIT_RSP: if (imem_rsp_valid) begin
          buf_push = 1'b1;
          state_d  = FETCH;
        end
        DRAIN: if (imem_rsp_valid) state_d = FETCH;
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      alive_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      alive_q    <= 1'b1;
    end
  end

  fetch_inst_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk       (clk),
    .rst       (reset),
    .push      (buf_push),
    .push_data (push_entry),
    .pop       (inst_ready),
    .flush     (buf_flush),
    .head      (head),
    .full      (buf_full),
    .empty     (buf_empty)
  );
endmodule

// File: tb/tb_pc_fetch_stage.sv
// Randomised bench for pc_fetch_stage: a behavioural memory plus a stream
// scoreboard predicting request addresses, buffer occupancy and decode data.
module tb_pc_fetch_stage;
  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam int          DEPTH  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] next_pc_in = '0;
  logic        redirect = 1'b0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        inst_valid;
  logic [31:0] inst_out, inst_pc, pc_plus4;
  logic        inst_ready = 1'b0;

  pc_fetch_stage #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .next_pc_in(next_pc_in), .redirect(redirect),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .inst_valid(inst_valid), .inst_out(inst_out),
    .inst_pc(inst_pc), .pc_plus4(pc_plus4), .inst_ready(inst_ready)
  );

  always #5 clk = ~clk;

  int ncmp = 0, nerr = 0, npops = 0;
  // Reference model state
  int          tb_cnt;
  bit          alive, pend, stale, saw_wrap;
  int          pend_wait, lat_min, lat_max;
  logic [31:0] pend_addr, exp_req, exp_pop;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    tb_cnt = 0; alive = 0; pend = 0; stale = 0; pend_wait = 0;
    exp_req = RST_PC; exp_pop = RST_PC;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst_out", inst_out, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_pc_plus4", pc_plus4, 32'd4);
  endtask

  // One clock cycle: drive at negedge, check 1ns later, advance model.
  task automatic step(input bit rdr, input logic [31:0] tgt, input bit rdy,
                      input bit ir, input bit late_rsp);
    bit rv, exp_rv, pop, push;
    @(negedge clk);
    redirect = rdr; next_pc_in = tgt; imem_req_ready = rdy; inst_ready = ir;
    rv = late_rsp || (pend && pend_wait == 0);
    imem_rsp_valid = rv;
    imem_rsp_data  = late_rsp ? 32'hDEAD_BEEF : inst_of(pend_addr);
    #1;
    exp_rv = alive && !pend && (tb_cnt < DEPTH) && !rdr;
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (exp_rv) chk("req_addr", imem_req_addr, exp_req);
    chk("inst_valid", 32'(inst_valid), 32'(tb_cnt != 0));
    pop = (tb_cnt != 0) && ir;
    if (pop) begin
      chk("inst_pc", inst_pc, exp_pop);
      chk("inst_out", inst_out, inst_of(exp_pop));
      chk("pc_plus4", pc_plus4, exp_pop + 32'd4);
      if (inst_pc == 32'hFFFF_FFFC && pc_plus4 == 32'h0) saw_wrap = 1;
      exp_pop += 32'd4;
      npops++;
    end
    push = rv && pend && !stale && !rdr;
    if (rdr) tb_cnt = 0;
    else     tb_cnt = tb_cnt + int'(push) - int'(pop);
    if (rv && pend) begin pend = 0; stale = 0; end
    else if (pend) pend_wait--;
    if (rdr && pend) stale = 1;
    if (exp_rv && rdy) begin
      pend = 1; stale = 0; pend_addr = exp_req;
      pend_wait = $urandom_range(lat_max, lat_min);
      exp_req += 32'd4;
    end
    if (rdr) begin exp_req = tgt & ~32'h3; exp_pop = tgt & ~32'h3; end
    alive = 1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk_reset_outputs();
    @(posedge clk);
    #2 reset = 1'b0;
    model_reset();
  endtask

  task automatic wait_pend(input string tag);
    for (int i = 0; i < 20 && !(pend && pend_wait > 0); i++) step(0, '0, 1, 1, 0);
    chk(tag, 32'(pend && pend_wait > 0), 32'd1);
  endtask

  initial begin
    model_reset();
    saw_wrap = 0; lat_min = 0; lat_max = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs();
    #1 reset = 1'b0;

    // 1-cycle memory, always ready, decode always consuming
    repeat (12) step(0, '0, 1, 1, 0);
    // Decode stall: buffer fills to DEPTH, then requests stop
    repeat (10) step(0, '0, 1, 0, 0);
    chk("stall_full", 32'(inst_valid), 32'd1);
    repeat (8) step(0, '0, 1, 1, 0);

    // Redirect while a response is in flight
    lat_min = 2; lat_max = 2;
    wait_pend("pend_before_redirect");
    step(1, 32'h0040_1003, 1, 1, 0);
    repeat (10) step(0, '0, 1, 1, 0);

    // Memory back-pressure: address must hold
    lat_min = 0; lat_max = 1;
    repeat (5) step(0, '0, 0, 1, 0);
    repeat (6) step(0, '0, 1, 1, 0);

    // Address wrap at the top of the space
    step(1, 32'hFFFF_FFF8, 1, 1, 0);
    repeat (12) step(0, '0, 1, 1, 0);
    chk("wrap_pop_seen", 32'(saw_wrap), 32'd1);

    // Asynchronous reset mid-WAIT_RSP, then a late stray response
    lat_min = 3; lat_max = 3;
    wait_pend("pend_before_reset");
    @(negedge clk);
    #2;
    do_reset();
    step(0, '0, 1, 1, 1);
    lat_min = 0; lat_max = 2;
    repeat (8) step(0, '0, 1, 1, 0);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      bit rdr;
      rdr = ($urandom_range(15, 0) == 0);
      step(rdr, $urandom, ($urandom_range(3, 0) != 0), ($urandom_range(4, 0) > 1), 0);
    end
    chk("progress", 32'(npops > 100), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
